// File: rtl/id_ex_operand_stage_pkg.sv
// Shared definitions for the ID/EX operand stage: datapath widths, ALU opcodes,
// operand-select encodings, the EX-stage register layout and the bypass match rule.
package id_ex_operand_stage_pkg;

  localparam int XLEN    = 32;
  localparam int RADDR_W = 5;

  localparam logic [3:0] ALU_ADD  = 4'h0;
  localparam logic [3:0] ALU_SUB  = 4'h1;
  localparam logic [3:0] ALU_SLL  = 4'h2;
  localparam logic [3:0] ALU_SLT  = 4'h3;
  localparam logic [3:0] ALU_SLTU = 4'h4;
  localparam logic [3:0] ALU_XOR  = 4'h5;
  localparam logic [3:0] ALU_SRL  = 4'h6;
  localparam logic [3:0] ALU_SRA  = 4'h7;
  localparam logic [3:0] ALU_OR   = 4'h8;
  localparam logic [3:0] ALU_AND  = 4'h9;
  localparam logic [3:0] ALU_PASS = 4'hA;
  localparam logic [3:0] ALU_GE   = 4'hB;
  localparam logic [3:0] ALU_GEU  = 4'hC;
  localparam logic [3:0] ALU_EQ   = 4'hD;
  localparam logic [3:0] ALU_NE   = 4'hE;

  localparam logic XSEL_RS1 = 1'b0;
  localparam logic XSEL_PC  = 1'b1;
  localparam logic YSEL_RS2 = 1'b0;
  localparam logic YSEL_IMM = 1'b1;

  typedef struct packed {
    logic               valid;
    logic               regWrite;
    logic               memRead;
    logic [3:0]         aluOp;
    logic               xSel;
    logic               ySel;
    logic [RADDR_W-1:0] rd;
    logic [RADDR_W-1:0] rs1;
    logic [RADDR_W-1:0] rs2;
  } ex_ctrl_t;

  typedef struct packed {
    logic [XLEN-1:0] rs1Data;
    logic [XLEN-1:0] rs2Data;
    logic [XLEN-1:0] imm;
    logic [XLEN-1:0] pc;
  } ex_data_t;

  // A bubble also zeroes rs1/rs2 so that no producer can ever forward into it.
  localparam ex_ctrl_t BUBBLE_CTRL = '{
    valid:    1'b0,
    regWrite: 1'b0,
    memRead:  1'b0,
    aluOp:    ALU_ADD,
    xSel:     XSEL_RS1,
    ySel:     YSEL_RS2,
    rd:       '0,
    rs1:      '0,
    rs2:      '0
  };

  function automatic logic fwdHit(input logic [RADDR_W-1:0] prodRd,
                                  input logic               prodRegWrite,
                                  input logic [RADDR_W-1:0] rs);
    return prodRegWrite && (prodRd != '0) && (prodRd == rs);
  endfunction

endpackage

// File: rtl/id_ex_operand_stage_if.sv
// Bundle of decode inputs, bypass producers and ALU-facing outputs of the ID/EX stage.
interface id_ex_if;
  import id_ex_operand_stage_pkg::*;

  logic               stall;
  logic               flush;
  logic               id_valid;
  logic [3:0]         id_aluOp;
  logic [RADDR_W-1:0] id_rs1;
  logic [RADDR_W-1:0] id_rs2;
  logic [XLEN-1:0]    id_rs1Data;
  logic [XLEN-1:0]    id_rs2Data;
  logic [XLEN-1:0]    id_imm;
  logic [XLEN-1:0]    id_pc;
  logic               id_xSel;
  logic               id_ySel;
  logic [RADDR_W-1:0] id_rd;
  logic               id_regWrite;
  logic               id_memRead;
  logic [RADDR_W-1:0] mem_rd;
  logic               mem_regWrite;
  logic [XLEN-1:0]    mem_result;
  logic [RADDR_W-1:0] wb_rd;
  logic               wb_regWrite;
  logic [XLEN-1:0]    wb_result;

  logic               hazard_stall;
  logic [3:0]         aluOp;
  logic [XLEN-1:0]    aluX;
  logic [XLEN-1:0]    aluY;
  logic               ex_valid;
  logic [RADDR_W-1:0] ex_rd;
  logic               ex_regWrite;
  logic               ex_memRead;
  logic [XLEN-1:0]    ex_storeData;

  modport master (
    output stall, flush, id_valid, id_aluOp, id_rs1, id_rs2, id_rs1Data, id_rs2Data,
           id_imm, id_pc, id_xSel, id_ySel, id_rd, id_regWrite, id_memRead,
           mem_rd, mem_regWrite, mem_result, wb_rd, wb_regWrite, wb_result,
    input  hazard_stall, aluOp, aluX, aluY, ex_valid, ex_rd, ex_regWrite, ex_memRead,
           ex_storeData
  );

  modport slave (
    input  stall, flush, id_valid, id_aluOp, id_rs1, id_rs2, id_rs1Data, id_rs2Data,
           id_imm, id_pc, id_xSel, id_ySel, id_rd, id_regWrite, id_memRead,
           mem_rd, mem_regWrite, mem_result, wb_rd, wb_regWrite, wb_result,
    output hazard_stall, aluOp, aluX, aluY, ex_valid, ex_rd, ex_regWrite, ex_memRead,
           ex_storeData
  );
endinterface

// File: rtl/id_ex_operand_stage_fwd_mux.sv
// Per-operand EX-time bypass: the youngest producer (MEM) beats WB, x0 is never forwarded.
module operand_fwd_mux
  import id_ex_operand_stage_pkg::*;
(
  input  logic [RADDR_W-1:0] exRs_i,
  input  logic [XLEN-1:0]    latched_i,
  input  logic [RADDR_W-1:0] memRd_i,
  input  logic               memRegWrite_i,
  input  logic [XLEN-1:0]    memResult_i,
  input  logic [RADDR_W-1:0] wbRd_i,
  input  logic               wbRegWrite_i,
  input  logic [XLEN-1:0]    wbResult_i,
  output logic [XLEN-1:0]    fwd_o
);

  always_comb begin
    fwd_o = latched_i;
    if (fwdHit(memRd_i, memRegWrite_i, exRs_i)) begin
      fwd_o = memResult_i;
    end else if (fwdHit(wbRd_i, wbRegWrite_i, exRs_i)) begin
      fwd_o = wbResult_i;
    end
  end

endmodule

// File: rtl/id_ex_operand_stage.sv
// ID/EX pipeline register with capture-time WB bypass, EX-time MEM/WB forwarding,
// load-use hazard detection and ALU source selection.
module id_ex_operand_stage
  import id_ex_operand_stage_pkg::*;
(
  input  logic    clk,
  input  logic    rst,
  id_ex_if.slave  bus
);

  ex_ctrl_t        exCtrl_q, exCtrl_d;
  ex_data_t        exData_q, exData_d;
  logic            hazardStall;
  logic [XLEN-1:0] rs1Fwd;
  logic [XLEN-1:0] rs2Fwd;

  assign hazardStall = bus.id_valid && exCtrl_q.valid && exCtrl_q.memRead &&
                       (exCtrl_q.rd != '0) &&
                       ((exCtrl_q.rd == bus.id_rs1) || (exCtrl_q.rd == bus.id_rs2));

  // Flush wins even over a global stall; a load-use hazard only bubbles when not stalled.
  always_comb begin
    exCtrl_d = exCtrl_q;
    exData_d = exData_q;
    if (bus.flush || (!bus.stall && hazardStall)) begin
      exCtrl_d = BUBBLE_CTRL;
      exData_d = '0;
    end else if (!bus.stall) begin
      exCtrl_d.valid    = bus.id_valid;
      exCtrl_d.regWrite = bus.id_regWrite & bus.id_valid;
      exCtrl_d.memRead  = bus.id_memRead & bus.id_valid;
      exCtrl_d.aluOp    = bus.id_aluOp;
      exCtrl_d.xSel     = bus.id_xSel;
      exCtrl_d.ySel     = bus.id_ySel;
      exCtrl_d.rd       = bus.id_rd;
      exCtrl_d.rs1      = bus.id_rs1;
      exCtrl_d.rs2      = bus.id_rs2;
      exData_d.rs1Data  = fwdHit(bus.wb_rd, bus.wb_regWrite, bus.id_rs1) ? bus.wb_result
                                                                         : bus.id_rs1Data;
      exData_d.rs2Data  = fwdHit(bus.wb_rd, bus.wb_regWrite, bus.id_rs2) ? bus.wb_result
                                                                         : bus.id_rs2Data;
      exData_d.imm      = bus.id_imm;
      exData_d.pc       = bus.id_pc;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      exCtrl_q <= BUBBLE_CTRL;
      exData_q <= '0;
    end else begin
      exCtrl_q <= exCtrl_d;
      exData_q <= exData_d;
    end
  end

  operand_fwd_mux u_fwdRs1 (
    .exRs_i        (exCtrl_q.rs1),
    .latched_i     (exData_q.rs1Data),
    .memRd_i       (bus.mem_rd),
    .memRegWrite_i (bus.mem_regWrite),
    .memResult_i   (bus.mem_result),
    .wbRd_i        (bus.wb_rd),
    .wbRegWrite_i  (bus.wb_regWrite),
    .wbResult_i    (bus.wb_result),
    .fwd_o         (rs1Fwd)
  );

  operand_fwd_mux u_fwdRs2 (
    .exRs_i        (exCtrl_q.rs2),
    .latched_i     (exData_q.rs2Data),
    .memRd_i       (bus.mem_rd),
    .memRegWrite_i (bus.mem_regWrite),
    .memResult_i   (bus.mem_result),
    .wbRd_i        (bus.wb_rd),
    .wbRegWrite_i  (bus.wb_regWrite),
    .wbResult_i    (bus.wb_result),
    .fwd_o         (rs2Fwd)
  );

  assign bus.hazard_stall = hazardStall;
  assign bus.aluOp        = exCtrl_q.aluOp;
  assign bus.aluX         = (exCtrl_q.xSel == XSEL_PC)  ? exData_q.pc  : rs1Fwd;
  assign bus.aluY         = (exCtrl_q.ySel == YSEL_IMM) ? exData_q.imm : rs2Fwd;
  assign bus.ex_storeData = rs2Fwd;
  assign bus.ex_valid     = exCtrl_q.valid;
  assign bus.ex_rd        = exCtrl_q.rd;
  assign bus.ex_regWrite  = exCtrl_q.regWrite;
  assign bus.ex_memRead   = exCtrl_q.memRead;

endmodule
